// File: rtl/mole_pkg.sv
// mole_pkg: shared definitions for the mole scoring slice.
//   MAX_HOLES   - widest hole/button vector any instance may use
//   LFSR_TAPS   - feedback mask for the 16-bit Fibonacci LFSR (taps 16,14,13,11)
//   bcd_digit_t - one packed BCD digit
//   onehot()    - hole index to one-hot mask, zero when idx is out of range
package mole_pkg;

  localparam int MAX_HOLES = 8;

  // Bit k of the mask selects LFSR stage k+1: stages 16,14,13,11.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef logic [3:0] bcd_digit_t;

  function automatic logic [MAX_HOLES-1:0] onehot(input logic [2:0] idx, input int n);
    logic [MAX_HOLES-1:0] v;
    v = '0;
    if (int'(idx) < n) v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mole_hit_scorer_bcd_sat_counter.sv
// bcd_sat_counter: multi-digit BCD up-counter that sticks at all-9s.
//   clk   - system clock
//   rst   - asynchronous active-high reset, clears the count
//   inc   - add one this cycle (ignored once saturated)
//   clr   - synchronous clear, wins over inc
//   value - packed BCD count, digit 0 in the LSBs
module bcd_sat_counter
  import mole_pkg::*;
#(
  parameter int SCORE_DIGITS = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      inc,
  input  logic                      clr,
  output logic [4*SCORE_DIGITS-1:0] value
);

  logic [SCORE_DIGITS-1:0] is_nine;
  logic [SCORE_DIGITS-1:0] carry;
  logic                    all_nines;

  assign all_nines = &is_nine;
  // Saturation is decided once at the bottom of the ripple chain.
  assign carry[0]  = inc & ~all_nines;

  generate
    for (genvar gi = 0; gi < SCORE_DIGITS; gi++) begin : g_digit
      bcd_digit_t digit_reg;

      assign is_nine[gi]     = (digit_reg == 4'd9);
      assign value[4*gi +: 4] = digit_reg;

      if (gi < SCORE_DIGITS - 1) begin : g_carry
        assign carry[gi+1] = carry[gi] & is_nine[gi];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          digit_reg <= '0;
        end else if (clr) begin
          digit_reg <= '0;
        end else if (carry[gi]) begin
          digit_reg <= is_nine[gi] ? 4'd0 : digit_reg + 4'd1;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/mole_hit_scorer.sv
// mole_hit_scorer: picks a hole per mole period, lights it while the window
// is open, classifies whack presses and keeps a saturating BCD score.
//   clk, rst          - clock, asynchronous active-high reset
//   game_in_progress  - game level from the sequencing FSM
//   mole_clk          - rising edge starts a new mole period
//   mole_up_window    - high while the mole may be hit
//   whack_buttons     - raw asynchronous button levels, active-high
//   mole_leds         - one-hot visible mole or zero
//   score_bcd         - BCD score, digit 0 in the LSBs
//   hit/miss/escape_pulse - one-cycle event strobes
//   cur_hole          - index of the current hole (debug)
module mole_hit_scorer
  import mole_pkg::*;
#(
  parameter int          N_HOLES      = 4,
  parameter int          SCORE_DIGITS = 3,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      game_in_progress,
  input  logic                      mole_clk,
  input  logic                      mole_up_window,
  input  logic [N_HOLES-1:0]        whack_buttons,
  output logic [N_HOLES-1:0]        mole_leds,
  output logic [4*SCORE_DIGITS-1:0] score_bcd,
  output logic                      hit_pulse,
  output logic                      miss_pulse,
  output logic                      escape_pulse,
  output logic [2:0]                cur_hole
);

  logic [15:0]          lfsr_reg;
  logic                 mole_clk_reg;
  logic                 window_reg;
  logic                 game_reg;
  logic [N_HOLES-1:0]   btn_sync1_reg;
  logic [N_HOLES-1:0]   btn_sync2_reg;
  logic [N_HOLES-1:0]   btn_prev_reg;
  logic                 hit_flag_reg;
  logic [2:0]           cur_hole_reg;
  logic [N_HOLES-1:0]   leds_reg;
  logic                 hit_reg;
  logic                 miss_reg;
  logic                 escape_reg;

  logic                 lfsr_fb;
  logic                 mole_rise;
  logic                 game_start;
  logic                 window_fall;
  logic                 new_mole;
  logic [N_HOLES-1:0]   btn_evt;
  logic [MAX_HOLES-1:0] btn_evt_wide;
  logic [MAX_HOLES-1:0] hole_mask;
  logic                 evt_valid;
  logic                 is_hit;
  logic                 is_miss;
  logic [2:0]           cand_hole;
  logic [2:0]           next_hole;

  assign lfsr_fb     = ^(lfsr_reg & LFSR_TAPS);
  assign mole_rise   = mole_clk & ~mole_clk_reg;
  assign game_start  = game_in_progress & ~game_reg;
  assign window_fall = ~mole_up_window & window_reg;
  assign new_mole    = mole_rise & game_in_progress;

  assign btn_evt   = btn_sync2_reg & ~btn_prev_reg;
  assign hole_mask = onehot(cur_hole_reg, N_HOLES);

  always_comb begin
    btn_evt_wide              = '0;
    btn_evt_wide[N_HOLES-1:0] = btn_evt;
  end

  // A game start in the same cycle swallows the press. Equality against a
  // one-hot mask also rules out multiple simultaneous presses.
  assign evt_valid = (|btn_evt) & game_in_progress & ~game_start;
  assign is_hit    = evt_valid & (btn_evt_wide == hole_mask) & mole_up_window & ~hit_flag_reg;
  assign is_miss   = evt_valid & ~is_hit;

  // Bump to the neighbouring hole so a hole never repeats back-to-back.
  assign cand_hole = 3'(int'(lfsr_reg[2:0]) % N_HOLES);
  assign next_hole = (cand_hole == cur_hole_reg) ? 3'((int'(cand_hole) + 1) % N_HOLES)
                                                 : cand_hole;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_reg      <= LFSR_SEED;
      mole_clk_reg  <= 1'b0;
      window_reg    <= 1'b0;
      game_reg      <= 1'b0;
      btn_sync1_reg <= '0;
      btn_sync2_reg <= '0;
      btn_prev_reg  <= '0;
      hit_flag_reg  <= 1'b0;
      cur_hole_reg  <= '0;
      leds_reg      <= '0;
      hit_reg       <= 1'b0;
      miss_reg      <= 1'b0;
      escape_reg    <= 1'b0;
    end else begin
      lfsr_reg      <= {lfsr_reg[14:0], lfsr_fb};
      mole_clk_reg  <= mole_clk;
      window_reg    <= mole_up_window;
      game_reg      <= game_in_progress;
      btn_sync1_reg <= whack_buttons;
      btn_sync2_reg <= btn_sync1_reg;
      btn_prev_reg  <= btn_sync2_reg;

      hit_reg    <= is_hit;
      miss_reg   <= is_miss;
      escape_reg <= window_fall & ~hit_flag_reg & game_in_progress;

      if (new_mole) cur_hole_reg <= next_hole;

      // A hit judged against the old mole must not leak into the new one.
      if (game_start || new_mole) hit_flag_reg <= 1'b0;
      else if (is_hit)            hit_flag_reg <= 1'b1;

      if (!game_start && mole_up_window && game_in_progress && !hit_flag_reg)
        leds_reg <= hole_mask[N_HOLES-1:0];
      else
        leds_reg <= '0;
    end
  end

  bcd_sat_counter #(
    .SCORE_DIGITS(SCORE_DIGITS)
  ) u_score (
    .clk  (clk),
    .rst  (rst),
    .inc  (is_hit),
    .clr  (game_start),
    .value(score_bcd)
  );

  assign mole_leds    = leds_reg;
  assign hit_pulse    = hit_reg;
  assign miss_pulse   = miss_reg;
  assign escape_pulse = escape_reg;
  assign cur_hole     = cur_hole_reg;

endmodule

// File: tb/tb_mole_hit_scorer.sv
module tb_mole_hit_scorer;

  logic        clk = 1'b0;
  logic        rst;
  logic        game_in_progress;
  logic        mole_clk;
  logic        mole_up_window;
  logic [3:0]  whack_buttons;
  logic [3:0]  mole_leds;
  logic [11:0] score_bcd;
  logic        hit_pulse;
  logic        miss_pulse;
  logic        escape_pulse;
  logic [2:0]  cur_hole;

  int errors = 0;
  int checks = 0;

  mole_hit_scorer #(.N_HOLES(4), .SCORE_DIGITS(3), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .game_in_progress(game_in_progress), .mole_clk(mole_clk),
    .mole_up_window(mole_up_window), .whack_buttons(whack_buttons), .mole_leds(mole_leds),
    .score_bcd(score_bcd), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
    .escape_pulse(escape_pulse), .cur_hole(cur_hole)
  );

  always #5 clk = ~clk;

  // Reference hole picker: Fibonacci LFSR (16,14,13,11) stepping every cycle.
  logic [15:0] m_lfsr;
  logic        m_mclk_q;
  logic [2:0]  m_hole;
  logic [1:0]  m_pick;
  always_comb begin
    m_pick = m_lfsr[1:0];
    if ({1'b0, m_pick} == m_hole) m_pick = m_pick + 2'd1;
  end
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lfsr   <= 16'hACE1;
      m_mclk_q <= 1'b0;
      m_hole   <= 3'd0;
    end else begin
      m_lfsr   <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      m_mclk_q <= mole_clk;
      if (mole_clk && !m_mclk_q && game_in_progress) m_hole <= {1'b0, m_pick};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_game();
    game_in_progress = 1'b0;
    cycles(2);
    game_in_progress = 1'b1;
    cycles(2);
  endtask

  // Press a mask, hold 5 cycles, watch 10 samples; returns pulse counts and
  // the sample index of the first hit pulse.
  task automatic press(input logic [3:0] mask, output int hits, output int misses, output int lat);
    hits = 0; misses = 0; lat = 0;
    whack_buttons = mask;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (hit_pulse) begin hits++; if (lat == 0) lat = i; end
      if (miss_pulse) misses++;
      if (i == 5) whack_buttons = 4'b0000;
    end
  endtask

  task automatic quick_hit();
    mole_clk = 1'b1; mole_up_window = 1'b1;
    cycles(2);
    mole_clk = 1'b0;
    whack_buttons = 4'b0001 << m_hole;
    cycles(4);
    whack_buttons = 4'b0000;
    cycles(3);
  endtask

  logic [2:0] seq_holes [2][5];

  // Five mole periods: window up for 12 of 24 cycles.
  task automatic run_sequence(input int which);
    start_game();
    for (int k = 0; k < 5; k++) begin
      mole_clk = 1'b1; mole_up_window = 1'b1;
      for (int c = 0; c < 24; c++) begin
        @(negedge clk);
        if (c == 1) begin
          seq_holes[which][k] = cur_hole;
          chk("seq_hole_model", 32'(cur_hole), 32'(m_hole));
          chk("seq_hole_range", 32'(cur_hole < 3'd4), 32'd1);
          if (k > 0) chk("seq_no_repeat", 32'(cur_hole != seq_holes[which][k-1]), 32'd1);
        end
        if (c >= 1) chk("seq_leds", 32'(mole_leds), (c <= 12) ? 32'(4'b0001 << m_hole) : 32'd0);
        if (c == 6)  mole_clk = 1'b0;
        if (c == 12) mole_up_window = 1'b0;
      end
    end
  endtask

  typedef struct {
    logic        new_mole;
    logic        win;
    logic        p_tgt;
    logic        p_nxt;
    int          exp_hit;
    int          exp_miss;
    logic [11:0] exp_score;
  } vec_t;

  initial begin
    vec_t vecs[7];
    int hits, misses, lat;
    logic [3:0] mask;
    logic e1, e2;

    vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1, 0, 12'h001}; // hit
    vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 0, 1, 12'h001}; // second press same window
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 0, 1, 12'h001}; // two buttons at once
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 0, 1, 12'h001}; // wrong hole
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1, 0, 12'h002}; // still hittable after misses
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 1, 12'h002}; // window low
    vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1, 0, 12'h003}; // hit again

    rst = 1'b1; game_in_progress = 1'b0; mole_clk = 1'b0; mole_up_window = 1'b0;
    whack_buttons = 4'b0000;
    cycles(3);
    chk("rst_leds", 32'(mole_leds), 32'd0);
    chk("rst_score", 32'(score_bcd), 32'd0);
    chk("rst_pulses", 32'({hit_pulse, miss_pulse, escape_pulse}), 32'd0);
    chk("rst_hole", 32'(cur_hole), 32'd0);
    rst = 1'b0;
    run_sequence(0);

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].new_mole) begin
        mole_clk = 1'b1; mole_up_window = vecs[v].win;
        cycles(2);
        mole_clk = 1'b0;
        cycles(2);
        chk("vec_hole", 32'(cur_hole), 32'(m_hole));
        chk("vec_leds", 32'(mole_leds), vecs[v].win ? 32'(4'b0001 << m_hole) : 32'd0);
      end else begin
        mole_up_window = vecs[v].win;
        cycles(2);
      end
      mask = 4'b0000;
      if (vecs[v].p_tgt) mask = mask | (4'b0001 << m_hole);
      if (vecs[v].p_nxt) mask = mask | (4'b0001 << ((m_hole + 3'd1) & 3'd3));
      press(mask, hits, misses, lat);
      $display("vec %0d: mask=%b hole=%0d hits=%0d misses=%0d score=%h", v, mask, m_hole, hits, misses, score_bcd);
      chk("vec_hits", 32'(hits), 32'(vecs[v].exp_hit));
      chk("vec_misses", 32'(misses), 32'(vecs[v].exp_miss));
      chk("vec_score", 32'(score_bcd), 32'(vecs[v].exp_score));
      if (vecs[v].exp_hit == 1) begin
        chk("hit_latency", 32'(lat == 3 || lat == 4), 32'd1);
        chk("leds_after_hit", 32'(mole_leds), 32'd0);
      end
    end

    // Escape: window closes with no press.
    mole_clk = 1'b1; mole_up_window = 1'b1;
    cycles(2);
    mole_clk = 1'b0;
    cycles(3);
    chk("escape_idle", 32'(escape_pulse), 32'd0);
    mole_up_window = 1'b0;
    @(negedge clk); e1 = escape_pulse;
    @(negedge clk); e2 = escape_pulse;
    $display("escape: e1=%b e2=%b", e1, e2);
    chk("escape_first", 32'(e1), 32'd1);
    chk("escape_width", 32'(e2), 32'd0);

    // No escape once the mole was hit.
    mole_clk = 1'b1; mole_up_window = 1'b1;
    cycles(2);
    mole_clk = 1'b0;
    press(4'b0001 << m_hole, hits, misses, lat);
    chk("hit_before_close", 32'(hits), 32'd1);
    mole_up_window = 1'b0;
    @(negedge clk); e1 = escape_pulse;
    @(negedge clk); e2 = escape_pulse;
    chk("no_escape_after_hit", 32'({e1, e2}), 32'd0);
    chk("score_004", 32'(score_bcd), 32'h004);

    // Game over: presses ignored, score held, LEDs dark.
    game_in_progress = 1'b0;
    mole_up_window = 1'b1;
    cycles(2);
    chk("idle_leds", 32'(mole_leds), 32'd0);
    press(4'b0001 << m_hole, hits, misses, lat);
    $display("idle press: hits=%0d misses=%0d score=%h", hits, misses, score_bcd);
    chk("idle_pulses", 32'(hits + misses), 32'd0);
    chk("idle_score", 32'(score_bcd), 32'h004);
    mole_up_window = 1'b0;

    // Saturation.
    start_game();
    chk("restart_score", 32'(score_bcd), 32'd0);
    for (int i = 0; i < 999; i++) begin
      quick_hit();
      if (i == 99) chk("score_carry_100", 32'(score_bcd), 32'h100);
    end
    $display("after 999 hits: score=%h", score_bcd);
    chk("score_999", 32'(score_bcd), 32'h999);
    mole_clk = 1'b1; mole_up_window = 1'b1;
    cycles(2);
    mole_clk = 1'b0;
    press(4'b0001 << m_hole, hits, misses, lat);
    chk("sat_hit_pulse", 32'(hits), 32'd1);
    chk("sat_score", 32'(score_bcd), 32'h999);
    mole_up_window = 1'b0;
    start_game();
    chk("newgame_score", 32'(score_bcd), 32'd0);

    // Reset mid-window with score 005, then replay the opening sequence.
    for (int i = 0; i < 5; i++) quick_hit();
    chk("score_005", 32'(score_bcd), 32'h005);
    mole_clk = 1'b1; mole_up_window = 1'b1;
    cycles(3);
    #2 rst = 1'b1;
    #1;
    chk("midrst_leds", 32'(mole_leds), 32'd0);
    chk("midrst_score", 32'(score_bcd), 32'd0);
    chk("midrst_hole", 32'(cur_hole), 32'd0);
    chk("midrst_pulses", 32'({hit_pulse, miss_pulse, escape_pulse}), 32'd0);
    mole_clk = 1'b0; mole_up_window = 1'b0; game_in_progress = 1'b0;
    cycles(3);
    rst = 1'b0;
    run_sequence(1);
    for (int k = 0; k < 5; k++) begin
      $display("seq %0d: run0=%0d run1=%0d", k, seq_holes[0][k], seq_holes[1][k]);
      chk("replay_hole", 32'(seq_holes[1][k]), 32'(seq_holes[0][k]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mole_hit_scorer.md
Name: mole_hit_scorer

Overview:
- Downstream consumer of whack_a_mole_fsm; runs in the same clock domain.
- On each new mole period it picks a pseudo-random hole and drives the hole LEDs while the mole-up window is open.
- Synchronises and edge-detects the player's whack buttons and classifies each press as hit or miss.
- Keeps a saturating BCD score plus hit, miss and escape pulses for the display and sound stages.

Parameters:
- N_HOLES, 4, number of holes and buttons; legal range 2..8.
- SCORE_DIGITS, 3, BCD score digits; score saturates at all-9s.
- LFSR_SEED, 16'hACE1, reset value of the 16-bit LFSR; must be nonzero.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- game_in_progress  in  1  level from FSM; synchronous to clk.
- mole_clk  in  1  from FSM; each rising edge starts a new mole period; synchronous to clk.
- mole_up_window  in  1  from FSM; high while the mole is up; synchronous to clk.
- whack_buttons  in  N_HOLES  raw, asynchronous button levels; active-high.
- mole_leds  out  N_HOLES  one-hot visible mole, or all zero.
- score_bcd  out  4*SCORE_DIGITS  BCD score; digit 0 in the LSBs.
- hit_pulse  out  1  one-cycle pulse on a scored hit.
- miss_pulse  out  1  one-cycle pulse on a wrong or untimely press.
- escape_pulse  out  1  one-cycle pulse when a window closes unhit.
- cur_hole  out  3  index of the current hole, for debug.

Behaviour:
- Reset (async, rst=1):
  - All outputs 0, cur_hole=0, all internal flags 0.
  - LFSR=LFSR_SEED.
  - Synchroniser and edge registers cleared.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Steps every clk cycle regardless of game state.
- Input registration: mole_clk, mole_up_window and game_in_progress are each registered once. Edges are detected from the current value against the registered value.
- Buttons:
  - 2-flop synchroniser per bit, then rising-edge detect.
  - A press becomes an event 3 cycles after the raw rise.
  - Holding a button produces exactly one event.
- Game start (rise of game_in_progress):
  - Clear score_bcd and the hit flag.
  - Set mole_leds=0.
  - cur_hole is unchanged.
- New mole (rise of mole_clk while game_in_progress=1):
  - Candidate = LFSR[2:0] mod N_HOLES.
  - If the candidate equals cur_hole, use (candidate+1) mod N_HOLES instead; no hole repeats back-to-back.
  - cur_hole updates on the next clk edge; latency 1 cycle from the mole_clk rise.
  - Hit flag is cleared.
- mole_leds:
  - Equals onehot(cur_hole) when mole_up_window=1, game_in_progress=1 and the hit flag is 0; otherwise 0.
  - Registered: follows its conditions with 1-cycle latency.
- Classification (per cycle with at least one button event, game_in_progress=1):
  - Hit: exactly one event bit, matching cur_hole, with mole_up_window=1 and hit flag 0.
    - hit_pulse=1 the next cycle.
    - Score increments.
    - Hit flag set; the mole hides.
  - Miss: any other case, including multiple simultaneous events, a correct hole after a hit, a press with the window low, or a wrong hole.
    - miss_pulse=1 the next cycle.
    - Score unchanged; it never decrements.
  - At most one hit per window.
- Escape: falling edge of mole_up_window with hit flag 0 and game_in_progress=1 gives escape_pulse=1 the next cycle.
- game_in_progress=0:
  - Button events are ignored (no pulses).
  - mole_leds=0.
  - Score holds its final value.
- Score arithmetic:
  - BCD ripple increment, carrying from digit 0 upward.
  - At all-9s the score holds and hit_pulse still fires.
- Simultaneous events:
  - mole_clk rise and a button event in the same cycle: the event is judged against the OLD cur_hole and the old hit flag; the new hole takes effect afterwards.
  - Game start and a button event in the same cycle: the clear wins; the event is ignored.
- rst asserted mid-game: immediate async clear of all state. Score and LEDs are 0 while rst=1.

Decomposition:
- Shared package mole_pkg:
  - MAX_HOLES=8.
  - LFSR_TAPS constant.
  - bcd_digit_t (4-bit) typedef.
  - Function onehot(idx, n).
- Sub-module bcd_sat_counter (SCORE_DIGITS param):
  - Ports: inc, clr, value; clr has priority.
  - Clock and async rst as in the parent.
  - Saturates at all-9s.

Test Plan:
- Reset, then start the game; step 5 mole_clk rises with mole_up_window high for 7 ms of each 12 ms period -> cur_hole never repeats consecutively, values are in 0..3, and mole_leds is one-hot only during the window.
- During a window with cur_hole=2, raise whack_buttons=4'b0100 -> hit_pulse 3–4 cycles later, score_bcd=12'h001, mole_leds=0 for the rest of the window; a second press in the same window -> miss_pulse, score stays 001.
- Press 4'b0110 while cur_hole=2 -> miss_pulse, score unchanged; press with mole_up_window=0 -> miss_pulse.
- Let a window close with no press -> escape_pulse exactly 1 cycle wide one cycle after the fall; with game_in_progress=0, presses -> no pulses and score held.
- Force 999 hits (SCORE_DIGITS=3) -> score_bcd=12'h999; one more hit -> still 999 and hit_pulse=1. New game start -> score 000.
- Assert rst mid-window with score 005 -> all outputs 0 immediately and LFSR reseeded; after release, start a game -> identical hole sequence to the first run.
